// File: rtl/exec_pkg.sv
// Execute-stage opcode, stall-range and memory-access-type constants.
// Defining EXEC_MADD_EN adds the MADD/MADDU/MSUB/MSUBU opcodes (21-24).
package exec_pkg;

    localparam int ALU_OP_LEN = 5;

    localparam logic [ALU_OP_LEN-1:0] ALU_OP_NOP   = 5'd0;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_ADD   = 5'd1;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SUB   = 5'd2;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_AND   = 5'd3;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_OR    = 5'd4;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_XOR   = 5'd5;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_NOR   = 5'd6;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLT   = 5'd7;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLTU  = 5'd8;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLL   = 5'd9;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRL   = 5'd10;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRA   = 5'd11;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_LUI   = 5'd12;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULT  = 5'd13;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULTU = 5'd14;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIV   = 5'd15;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIVU  = 5'd16;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTHI  = 5'd17;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTLO  = 5'd18;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFHI  = 5'd19;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFLO  = 5'd20;
`ifdef EXEC_MADD_EN
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MADD  = 5'd21;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MADDU = 5'd22;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MSUB  = 5'd23;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_MSUBU = 5'd24;
`endif

    // Opcode range the decode stage must hold back while HI/LO is busy.
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_STALL_MIN = ALU_OP_MULT;
`ifdef EXEC_MADD_EN
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_STALL_MAX = ALU_OP_MSUBU;
`else
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_STALL_MAX = ALU_OP_MFLO;
`endif

    localparam int MEM_TYPE_LEN = 2;

    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_NONE = 2'd0;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_WORD = 2'd1;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_HALF = 2'd2;
    localparam logic [MEM_TYPE_LEN-1:0] MEM_TYPE_BYTE = 2'd3;

endpackage

// File: rtl/hilo_muldiv.sv
// HI/LO registers with the multiply/divide unit and its busy counter.
// EXEC_MADD_EN adds multiply-accumulate/subtract into {HI,LO}.
module hilo_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ALU_OP_LEN-1:0] alu_op,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    input  logic [31:0]           mt_data,
    output logic [31:0]           hi,
    output logic [31:0]           lo,
    output logic                  busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic        div_zero;
    logic        div_by_m1;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;

    assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    assign div_zero  = (op_b == 32'd0);
    assign div_by_m1 = (op_b == 32'hFFFF_FFFF);
    // Substitute 1 so the dividers never see zero; the result is discarded then.
    assign divisor   = div_zero ? 32'd1 : op_b;

    always_comb begin
        // Division by -1 is handled apart to sidestep the MIN/-1 overflow case.
        if (div_by_m1) begin
            quot_s = 32'd0 - op_a;
            rem_s  = 32'd0;
        end else begin
            quot_s = 32'($signed(op_a) / $signed(divisor));
            rem_s  = 32'($signed(op_a) % $signed(divisor));
        end
        quot_u = op_a / divisor;
        rem_u  = op_a % divisor;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        issue = 1'b0;
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        case (alu_op)
            ALU_OP_MULT: begin
                {hi_d, lo_d} = prod_s;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
            ALU_OP_MULTU: begin
                {hi_d, lo_d} = prod_u;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
            ALU_OP_DIV: begin
                if (!div_zero) begin
                    lo_d = quot_s;
                    hi_d = rem_s;
                end
                cnt_d = DIV_LOAD;
                issue = 1'b1;
            end
            ALU_OP_DIVU: begin
                if (!div_zero) begin
                    lo_d = quot_u;
                    hi_d = rem_u;
                end
                cnt_d = DIV_LOAD;
                issue = 1'b1;
            end
            ALU_OP_MTHI: hi_d = mt_data;
            ALU_OP_MTLO: lo_d = mt_data;
`ifdef EXEC_MADD_EN
            ALU_OP_MADD: begin
                {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
            ALU_OP_MADDU: begin
                {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
            ALU_OP_MSUB: begin
                {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
            ALU_OP_MSUBU: begin
                {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
                cnt_d        = MULT_LOAD;
                issue        = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = issue || (cnt_q != '0);

endmodule

// File: rtl/exec_stage_unit.sv
// MIPS execute stage: operand select, ALU, overflow, alignment check, HI/LO unit.
// Define EXEC_MADD_EN to enable the multiply-accumulate opcodes.
module exec_stage_unit
    import exec_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             grf_in0,
    input  logic [31:0]             grf_in1,
    input  logic                    alu_src0,
    input  logic                    alu_src1,
    input  logic [ALU_OP_LEN-1:0]   alu_op,
    input  logic [4:0]              sa,
    input  logic [31:0]             ext_imm,
    input  logic [MEM_TYPE_LEN-1:0] mem_type,
    output logic [31:0]             alu_result,
    output logic                    overflowed,
    output logic                    mem_unaligned,
    output logic                    alu_busy
);

    logic [31:0] op_a, op_b;
    logic [31:0] sum, diff, neg_b;
    logic        add_ovf, sub_ovf;
    logic [31:0] hi, lo;

    assign op_a = alu_src0 ? {27'd0, sa} : grf_in0;
    assign op_b = alu_src1 ? ext_imm : grf_in1;

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign neg_b = 32'd0 - op_b;
    // Subtraction overflow uses the sign of the negated operand, as for an add.
    assign add_ovf = (op_a[31] == op_b[31])  && (sum[31]  != op_a[31]);
    assign sub_ovf = (op_a[31] == neg_b[31]) && (diff[31] != op_a[31]);

    always_comb begin
        alu_result = 32'd0;
        overflowed = 1'b0;
        case (alu_op)
            ALU_OP_ADD: begin
                alu_result = sum;
                overflowed = add_ovf;
            end
            ALU_OP_SUB: begin
                alu_result = diff;
                overflowed = sub_ovf;
            end
            ALU_OP_AND:  alu_result = op_a & op_b;
            ALU_OP_OR:   alu_result = op_a | op_b;
            ALU_OP_XOR:  alu_result = op_a ^ op_b;
            ALU_OP_NOR:  alu_result = ~(op_a | op_b);
            ALU_OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_OP_SLTU: alu_result = {31'd0, op_a < op_b};
            ALU_OP_SLL:  alu_result = op_b << op_a[4:0];
            ALU_OP_SRL:  alu_result = op_b >> op_a[4:0];
            ALU_OP_SRA:  alu_result = 32'($signed(op_b) >>> op_a[4:0]);
            ALU_OP_LUI:  alu_result = {op_b[15:0], 16'd0};
            ALU_OP_MFHI: alu_result = hi;
            ALU_OP_MFLO: alu_result = lo;
            default:     alu_result = 32'd0;
        endcase
    end

    always_comb begin
        mem_unaligned = 1'b0;
        case (mem_type)
            MEM_TYPE_WORD: mem_unaligned = (alu_result[1:0] != 2'b00);
            MEM_TYPE_HALF: mem_unaligned = alu_result[0];
            default:       mem_unaligned = 1'b0;
        endcase
    end

    hilo_muldiv #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_hilo_muldiv (
        .clk     (clk),
        .reset   (reset),
        .alu_op  (alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .mt_data (grf_in0),
        .hi      (hi),
        .lo      (lo),
        .busy    (alu_busy)
    );

endmodule

// File: tb/tb_exec_stage_unit.sv
// Scoreboard bench for exec_stage_unit: directed cases plus random ops against
// a behavioural model of the ALU and HI/LO unit.
module tb_exec_stage_unit;
    import exec_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef EXEC_MADD_EN
    localparam bit HAS_MADD = 1'b1;
`else
    localparam bit HAS_MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] grf_in0, grf_in1, ext_imm;
    logic        alu_src0, alu_src1;
    logic [4:0]  alu_op, sa;
    logic [1:0]  mem_type;
    logic [31:0] alu_result;
    logic        overflowed, mem_unaligned, alu_busy;

    exec_stage_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .grf_in0       (grf_in0),
        .grf_in1       (grf_in1),
        .alu_src0      (alu_src0),
        .alu_src1      (alu_src1),
        .alu_op        (alu_op),
        .sa            (sa),
        .ext_imm       (ext_imm),
        .mem_type      (mem_type),
        .alu_result    (alu_result),
        .overflowed    (overflowed),
        .mem_unaligned (mem_unaligned),
        .alu_busy      (alu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        ovf;
        logic        unal;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: HI/LO as one 64-bit value, busy as "last busy cycle".
    logic [63:0] m_hilo;
    int          cyc;
    int          busy_until;
    logic [4:0]  cur_op;
    logic [31:0] cur_a, cur_b, cur_g0;

    function automatic bit is_muldiv(input logic [4:0] op);
        return (op >= 5'd13 && op <= 5'd16) || (HAS_MADD && op >= 5'd21 && op <= 5'd24);
    endfunction

    function automatic exp_t predict(input string nm, input logic [4:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] mt);
        exp_t        e;
        logic [31:0] r, nb;
        e.name = nm;
        e.ovf  = 1'b0;
        r      = 32'd0;
        nb     = 32'd0 - b;
        case (op)
            5'd1:  begin r = a + b;  e.ovf = (a[31] == b[31])  && (r[31] != a[31]); end
            5'd2:  begin r = a + nb; e.ovf = (a[31] == nb[31]) && (r[31] != a[31]); end
            5'd3:  r = a & b;
            5'd4:  r = a | b;
            5'd5:  r = a ^ b;
            5'd6:  r = ~(a | b);
            5'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd8:  r = (a < b) ? 32'd1 : 32'd0;
            5'd9:  r = b << a[4:0];
            5'd10: r = b >> a[4:0];
            5'd11: r = 32'($signed(b) >>> a[4:0]);
            5'd12: r = b * 32'd65536;
            5'd19: r = m_hilo[63:32];
            5'd20: r = m_hilo[31:0];
            default: r = 32'd0;
        endcase
        e.result = r;
        e.unal   = (mt == 2'd1) ? (r % 4 != 0) : (mt == 2'd2) ? (r % 2 != 0) : 1'b0;
        e.busy   = is_muldiv(op) || (cyc <= busy_until);
        return e;
    endfunction

    task automatic model_commit(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] g0);
        longint sp;
        longint up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        case (op)
            5'd13: begin m_hilo = sp; busy_until = cyc + MULT_N; end
            5'd14: begin m_hilo = up; busy_until = cyc + MULT_N; end
            5'd15: begin
                if (b != 0) begin
                    m_hilo[31:0]  = 32'($signed(a) / $signed(b));
                    m_hilo[63:32] = 32'($signed(a) % $signed(b));
                end
                busy_until = cyc + DIV_N;
            end
            5'd16: begin
                if (b != 0) begin
                    m_hilo[31:0]  = a / b;
                    m_hilo[63:32] = a % b;
                end
                busy_until = cyc + DIV_N;
            end
            5'd17: m_hilo[63:32] = g0;
            5'd18: m_hilo[31:0]  = g0;
            default: ;
        endcase
        if (HAS_MADD) begin
            case (op)
                5'd21: begin m_hilo = m_hilo + sp; busy_until = cyc + MULT_N; end
                5'd22: begin m_hilo = m_hilo + up; busy_until = cyc + MULT_N; end
                5'd23: begin m_hilo = m_hilo - sp; busy_until = cyc + MULT_N; end
                5'd24: begin m_hilo = m_hilo - up; busy_until = cyc + MULT_N; end
                default: ;
            endcase
        end
    endtask

    task automatic step(input string nm, input logic rst_v, input logic [4:0] op,
                        input logic [31:0] g0, input logic [31:0] g1, input logic [31:0] imm,
                        input logic s0, input logic s1, input logic [4:0] sav,
                        input logic [1:0] mt);
        logic [31:0] a, b;
        @(posedge clk);
        if (reset) model_commit(cur_op, cur_a, cur_b, cur_g0);
        cyc++;
        #1;
        reset    = rst_v;
        alu_op   = op;
        grf_in0  = g0;
        grf_in1  = g1;
        ext_imm  = imm;
        alu_src0 = s0;
        alu_src1 = s1;
        sa       = sav;
        mem_type = mt;
        if (!rst_v) begin
            m_hilo     = 64'd0;
            busy_until = -1;
        end
        a      = s0 ? {27'd0, sav} : g0;
        b      = s1 ? imm : g1;
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
        cur_g0 = g0;
        sb_q.push_back(predict(nm, op, a, b, mt));
    endtask

    task automatic op2(input string nm, input logic [4:0] op, input logic [31:0] g0,
                       input logic [31:0] g1);
        step(nm, 1'b1, op, g0, g1, 32'd0, 1'b0, 1'b0, 5'd0, 2'd0);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a settled output every cycle; compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.name, "result", alu_result, e.result);
                chk(e.name, "ovf", {31'd0, overflowed}, {31'd0, e.ovf});
                chk(e.name, "unaligned", {31'd0, mem_unaligned}, {31'd0, e.unal});
                chk(e.name, "busy", {31'd0, alu_busy}, {31'd0, e.busy});
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 16));
            2:       return edges[$urandom_range(0, 4)];
            default: return 32'd0 - 32'($urandom_range(1, 16));
        endcase
    endfunction

    initial begin
        logic [4:0]  rop, rsa;
        logic [31:0] x, y, im;
        logic        r0, r1;
        reset      = 1'b0;
        alu_op     = 5'd0;
        grf_in0    = 32'd0;
        grf_in1    = 32'd0;
        ext_imm    = 32'd0;
        alu_src0   = 1'b0;
        alu_src1   = 1'b0;
        sa         = 5'd0;
        mem_type   = 2'd0;
        m_hilo     = 64'd0;
        cyc        = 0;
        busy_until = -1;
        cur_op     = 5'd0;
        cur_a      = 32'd0;
        cur_b      = 32'd0;
        cur_g0     = 32'd0;

        step("reset", 1'b0, ALU_OP_NOP, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        op2("rst_mfhi", ALU_OP_MFHI, 32'd0, 32'd0);
        op2("rst_mflo", ALU_OP_MFLO, 32'd0, 32'd0);

        op2("add_ovf", ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1);
        op2("sub_ovf", ALU_OP_SUB, 32'h8000_0000, 32'd1);
        step("add_imm", 1'b1, ALU_OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b0, 1'b1, 5'd0, 2'd0);
        step("sra_sa", 1'b1, ALU_OP_SRA, 32'd0, 32'hF000_0000, 32'd0, 1'b1, 1'b0, 5'd4, 2'd0);
        op2("sltu", ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        op2("slt", ALU_OP_SLT, 32'd1, 32'hFFFF_FFFF);
        step("lui", 1'b1, ALU_OP_LUI, 32'd0, 32'd0, 32'h0000_ABCD, 1'b0, 1'b1, 5'd0, 2'd0);

        step("word_1002", 1'b1, ALU_OP_ADD, 32'h1000, 32'd0, 32'd2, 1'b0, 1'b1, 5'd0, 2'd1);
        step("word_1004", 1'b1, ALU_OP_ADD, 32'h1000, 32'd0, 32'd4, 1'b0, 1'b1, 5'd0, 2'd1);
        step("half_1003", 1'b1, ALU_OP_ADD, 32'h1000, 32'd0, 32'd3, 1'b0, 1'b1, 5'd0, 2'd2);
        step("byte_1003", 1'b1, ALU_OP_ADD, 32'h1000, 32'd0, 32'd3, 1'b0, 1'b1, 5'd0, 2'd3);

        op2("mult", ALU_OP_MULT, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < MULT_N + 1; i++) op2("mult_wait", ALU_OP_NOP, 32'd0, 32'd0);
        op2("mult_hi", ALU_OP_MFHI, 32'd0, 32'd0);
        op2("mult_lo", ALU_OP_MFLO, 32'd0, 32'd0);

        op2("div", ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < DIV_N + 1; i++) op2("div_wait", ALU_OP_NOP, 32'd0, 32'd0);
        op2("div_hi", ALU_OP_MFHI, 32'd0, 32'd0);
        op2("div_lo", ALU_OP_MFLO, 32'd0, 32'd0);

        op2("divu0", ALU_OP_DIVU, 32'd5, 32'd0);
        op2("divu0_hi", ALU_OP_MFHI, 32'd0, 32'd0);
        op2("divu0_lo", ALU_OP_MFLO, 32'd0, 32'd0);
        for (int i = 0; i < DIV_N; i++) op2("divu0_wait", ALU_OP_NOP, 32'd0, 32'd0);

        op2("div2", ALU_OP_DIV, 32'd100, 32'd7);
        op2("div2_wait", ALU_OP_NOP, 32'd0, 32'd0);
        op2("div2_wait", ALU_OP_NOP, 32'd0, 32'd0);
        step("mid_reset", 1'b0, ALU_OP_NOP, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        step("in_reset", 1'b0, ALU_OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        op2("post_rst_hi", ALU_OP_MFHI, 32'd0, 32'd0);
        op2("post_rst_lo", ALU_OP_MFLO, 32'd0, 32'd0);

        op2("mtlo", ALU_OP_MTLO, 32'h1234, 32'd0);
        op2("mflo", ALU_OP_MFLO, 32'd0, 32'd0);
        op2("mthi", ALU_OP_MTHI, 32'hCAFE_0001, 32'd0);
        op2("mfhi", ALU_OP_MFHI, 32'd0, 32'd0);

        for (int i = 0; i < 600; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? ALU_OP_NOP : 5'($urandom_range(0, 31));
            x   = rnd_operand();
            y   = rnd_operand();
            im  = rnd_operand();
            r0  = ($urandom_range(0, 3) == 0);
            r1  = ($urandom_range(0, 2) == 0);
            rsa = 5'($urandom_range(0, 31));
            // Keep clear of the undefined MIN / -1 signed quotient.
            if (rop == ALU_OP_DIV && !r0 && x == 32'h8000_0000) begin
                if (y == 32'hFFFF_FFFF) y = 32'd3;
                if (im == 32'hFFFF_FFFF) im = 32'd3;
            end
            step("random", 1'b1, rop, x, y, im, r0, r1, rsa, 2'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage_unit.md
Name: exec_stage_unit

Overview:
- Execute-stage datapath of the 5-stage MIPS pipeline, sitting between the D/E and E/M pipeline registers.
- Selects operands and computes a combinational ALU result with a signed-overflow flag.
- Flags misaligned memory addresses.
- Owns the HI/LO registers plus a multi-cycle multiply/divide unit whose busy flag drives the decode-stage stall logic.

Parameters:
- MULT_CYCLES, 5, busy cycles after a multiply issue.
- DIV_CYCLES, 10, busy cycles after a divide issue.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- grf_in0  in  32  forwarded rs value.
- grf_in1  in  32  forwarded rt value.
- alu_src0  in  1  0: A=grf_in0; 1: A={27'b0,sa}.
- alu_src1  in  1  0: B=grf_in1; 1: B=ext_imm.
- alu_op  in  5  operation code from exec_pkg.
- sa  in  5  shift amount.
- ext_imm  in  32  pre-extended immediate.
- mem_type  in  2  0 NONE, 1 WORD, 2 HALF, 3 BYTE.
- alu_result  out  32  combinational result (also the memory address).
- overflowed  out  1  signed overflow of ADD/SUB.
- mem_unaligned  out  1  address misaligned for mem_type.
- alu_busy  out  1  HI/LO unit busy.

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLT, 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 LUI, 13 MULT, 14 MULTU, 15 DIV, 16 DIVU, 17 MTHI, 18 MTLO, 19 MFHI, 20 MFLO. Codes 21-31 are reserved.
- ALU_OP_STALL_MIN=13 and ALU_OP_STALL_MAX=20 (24 with the optional feature).
- Datapath outputs are purely combinational.
- ADD/SUB: 32-bit wrap result. overflowed = sign(A)==sign(B')!=sign(result), where B'=B for ADD and B'=-B for SUB. overflowed=0 for all other ops.
- SLT/SLTU: signed/unsigned compare, result 0 or 1.
- SLL/SRL/SRA: shift B by A[4:0].
- LUI: B<<16.
- NOP, reserved codes and MULT..MTLO: alu_result=0, no side effects.
- MFHI/MFLO: alu_result=HI/LO, even while busy.
- mem_unaligned: WORD and alu_result[1:0]!=0, or HALF and alu_result[0]!=0. Always 0 for BYTE/NONE.
- HI/LO commit on the clk edge where the op is presented:
  - MULT/MULTU: {HI,LO}=A*B, signed/unsigned 64-bit product.
  - DIV/DIVU: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. Divisor 0: HI/LO unchanged, busy timing identical.
  - MTHI/MTLO: HI/LO=grf_in0, no busy.
- Busy counter is loaded with MULT_CYCLES or DIV_CYCLES at the issue edge and decrements each clock to 0.
- alu_busy = (alu_op is a mult/div op) || counter!=0. It is high in the issue cycle plus N following cycles.
- A new mult/div while counter!=0 overwrites HI/LO and reloads the counter.
- Reset (async, low): HI=LO=0, counter=0, alu_busy=0 once alu_op is NOP.
- Reset mid-operation abandons the operation.

Optional Feature:
- EXEC_MADD_EN defined: adds 21 MADD, 22 MADDU, 23 MSUB, 24 MSUBU. These do {HI,LO}±=A*B (signed/unsigned, 64-bit wrap) with MULT_CYCLES busy, and ALU_OP_STALL_MAX=24.
- Undefined: codes 21-24 behave as NOP and ALU_OP_STALL_MAX=20.

Decomposition:
- Package exec_pkg holds:
  - ALU_OP_LEN=5 and all ALU_OP_* codes;
  - ALU_OP_STALL_MIN and ALU_OP_STALL_MAX;
  - MEM_TYPE_LEN=2 and the MEM_TYPE_* codes.
- One sub-module, hilo_muldiv, holds the HI/LO registers, the busy counter and the mult/div/madd arithmetic.
- The top level keeps operand muxing, the ALU, overflow detection and the alignment check.

Test Plan:
- ADD A=0x7FFFFFFF, B=1 -> alu_result=0x80000000, overflowed=1. SUB 0x80000000-1 -> 0x7FFFFFFF, overflowed=1. ADD 5+(-3) -> 2, overflowed=0.
- alu_src0=1, sa=4, SRA B=0xF0000000 -> 0xFF000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT -> 0.
- mem_type=WORD: address 0x1002 -> mem_unaligned=1, 0x1004 -> 0. HALF 0x1003 -> 1. BYTE 0x1003 -> 0.
- MULT 0xFFFFFFFF*2 -> alu_busy high in the issue cycle plus 5 more, then low. MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy 1+10 cycles. DIVU by 0 -> HI/LO unchanged.
- Assert reset low mid-DIV -> alu_busy drops immediately (alu_op=NOP), MFHI=MFLO=0. MTLO 0x1234 then MFLO -> 0x1234 with no busy.
